// File: rtl/lab5_isa_pkg.sv
// Shared ISA definitions for the lab 5 processor: opcode values, instruction
// field positions, fetch-state encoding and the decoded-flag bundle. The
// control FSM and the fetch/decode block both import this package so the
// opcode map lives in exactly one place.
package lab5_isa_pkg;

   // Instruction byte layout: [7:4] opcode, [3:2] rx, [1:0] ry, [3:0] imm4
   localparam int INSTR_WIDTH  = 8;
   localparam int OPCODE_WIDTH = 4;
   localparam int OPCODE_MSB   = 7;
   localparam int OPCODE_LSB   = 4;
   localparam int RX_MSB       = 3;
   localparam int RX_LSB       = 2;
   localparam int RY_MSB       = 1;
   localparam int RY_LSB       = 0;
   localparam int IMM_MSB      = 3;
   localparam int IMM_LSB      = 0;

   // Opcode map; 0xC..0xF are unassigned and decode as illegal
   localparam logic [OPCODE_WIDTH-1:0] OP_PAUSE  = 4'h0;
   localparam logic [OPCODE_WIDTH-1:0] OP_BR     = 4'h1;
   localparam logic [OPCODE_WIDTH-1:0] OP_BRZ    = 4'h2;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI   = 4'h3;
   localparam logic [OPCODE_WIDTH-1:0] OP_SUBI   = 4'h4;
   localparam logic [OPCODE_WIDTH-1:0] OP_SR0    = 4'h5;
   localparam logic [OPCODE_WIDTH-1:0] OP_SRH0   = 4'h6;
   localparam logic [OPCODE_WIDTH-1:0] OP_CLR    = 4'h7;
   localparam logic [OPCODE_WIDTH-1:0] OP_MOV    = 4'h8;
   localparam logic [OPCODE_WIDTH-1:0] OP_MOVA   = 4'h9;
   localparam logic [OPCODE_WIDTH-1:0] OP_MOVR   = 4'hA;
   localparam logic [OPCODE_WIDTH-1:0] OP_MOVRHS = 4'hB;

   // Fetch sequencing: WAIT lets the registered ROM catch up with a new
   // address, LOAD captures its data, HOLD keeps the instruction until the
   // control FSM asks for a different PC.
   typedef enum logic [1:0] {
      FETCH_WAIT = 2'd0,
      FETCH_LOAD = 2'd1,
      FETCH_HOLD = 2'd2
   } fetchState_t;

   // One-hot decode result; at most one member is ever set
   typedef struct packed {
      logic pause;
      logic br;
      logic brz;
      logic addi;
      logic subi;
      logic sr0;
      logic srh0;
      logic clr;
      logic mov;
      logic mova;
      logic movr;
      logic movrhs;
      logic illegal;
   } decodeFlags_t;

   // Operand fields pulled out of the instruction byte
   typedef struct packed {
      logic [1:0] rx;
      logic [1:0] ry;
      logic [3:0] imm4;
   } instrFields_t;

   // Extracts the opcode nibble from an instruction byte
   function automatic logic [OPCODE_WIDTH-1:0] opcodeOf(input logic [INSTR_WIDTH-1:0] instrByte);
      return instrByte[OPCODE_MSB:OPCODE_LSB];
   endfunction

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Bundle between the fetch/decode block and its surroundings: PC requests
// from the control FSM, the program ROM bus and the decoded instruction.
// The fetch/decode block is the master; the control FSM / ROM side is the
// slave.
interface instr_fetch_decode_if #(
   parameter int PC_WIDTH = 8
);

   logic                increment_pc;
   logic                commit_branch;
   logic [PC_WIDTH-1:0] branch_target;
   logic [7:0]          rom_q;
   logic [PC_WIDTH-1:0] rom_addr;
   logic [PC_WIDTH-1:0] pc;
   logic [7:0]          instr;
   logic                instr_valid;
   logic                br;
   logic                brz;
   logic                addi;
   logic                subi;
   logic                sr0;
   logic                srh0;
   logic                clr;
   logic                mov;
   logic                mova;
   logic                movr;
   logic                movrhs;
   logic                pause;
   logic                illegal;
   logic [1:0]          rx;
   logic [1:0]          ry;
   logic [3:0]          imm4;

   modport master (
      input  increment_pc, commit_branch, branch_target, rom_q,
      output rom_addr, pc, instr, instr_valid,
      output br, brz, addi, subi, sr0, srh0, clr, mov, mova, movr, movrhs, pause, illegal,
      output rx, ry, imm4
   );

   modport slave (
      output increment_pc, commit_branch, branch_target, rom_q,
      input  rom_addr, pc, instr, instr_valid,
      input  br, brz, addi, subi, sr0, srh0, clr, mov, mova, movr, movrhs, pause, illegal,
      input  rx, ry, imm4
   );

endinterface

// File: rtl/instr_fetch_decode_decoder.sv
// Purely combinational opcode decoder: turns one instruction byte into the
// one-hot opcode flags (plus illegal) and its operand fields.
module instr_decode
   import lab5_isa_pkg::*;
(
   input  logic [INSTR_WIDTH-1:0] romByte_i,
   output decodeFlags_t           flags_o,
   output instrFields_t           fields_o
);

   logic [OPCODE_WIDTH-1:0] opcode;

   assign opcode = opcodeOf(romByte_i);

   // Map the opcode nibble onto exactly one flag; anything unassigned is illegal
   always_comb begin
      flags_o = '0;
      case (opcode)
         OP_PAUSE:  flags_o.pause   = 1'b1;
         OP_BR:     flags_o.br      = 1'b1;
         OP_BRZ:    flags_o.brz     = 1'b1;
         OP_ADDI:   flags_o.addi    = 1'b1;
         OP_SUBI:   flags_o.subi    = 1'b1;
         OP_SR0:    flags_o.sr0     = 1'b1;
         OP_SRH0:   flags_o.srh0    = 1'b1;
         OP_CLR:    flags_o.clr     = 1'b1;
         OP_MOV:    flags_o.mov     = 1'b1;
         OP_MOVA:   flags_o.mova    = 1'b1;
         OP_MOVR:   flags_o.movr    = 1'b1;
         OP_MOVRHS: flags_o.movrhs  = 1'b1;
         default:   flags_o.illegal = 1'b1;
      endcase
   end

   // Operand fields are fixed bit slices regardless of opcode
   always_comb begin
      fields_o      = '0;
      fields_o.rx   = romByte_i[RX_MSB:RX_LSB];
      fields_o.ry   = romByte_i[RY_MSB:RY_LSB];
      fields_o.imm4 = romByte_i[IMM_MSB:IMM_LSB];
   end

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch and decode stage. Holds the program counter, drives the
// registered program ROM, captures the returned byte into the instruction
// register and presents registered one-hot decode flags. Any PC request
// from the control FSM restarts the fetch so a stale byte is never marked
// valid. Every output is a register (rom_addr is the pc register itself).
module instr_fetch_decode
   import lab5_isa_pkg::*;
#(
   parameter int                  PC_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
)
(
   input  logic                  clk,
   input  logic                  reset_n,
   instr_fetch_decode_if.master  bus_if
);

   fetchState_t         state_q;
   logic [PC_WIDTH-1:0] pc_q;
   logic [PC_WIDTH-1:0] pc_d;
   logic                pcRequest;
   logic [7:0]          instr_q;
   logic                instrValid_q;
   decodeFlags_t        flags_q;
   instrFields_t        fields_q;
   decodeFlags_t        decodedFlags;
   instrFields_t        decodedFields;

   instr_decode decoder (
      .romByte_i (bus_if.rom_q),
      .flags_o   (decodedFlags),
      .fields_o  (decodedFields)
   );

   // Next PC: a committed branch beats a plain increment; increment wraps naturally
   always_comb begin
      pc_d      = pc_q;
      pcRequest = 1'b0;
      if (bus_if.commit_branch) begin
         pc_d      = bus_if.branch_target;
         pcRequest = 1'b1;
      end else if (bus_if.increment_pc) begin
         pc_d      = pc_q + PC_WIDTH'(1);
         pcRequest = 1'b1;
      end
   end

   // Fetch FSM with registered outputs; reset first, then PC requests, then sequencing
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= FETCH_WAIT;
         pc_q         <= RESET_PC;
         instr_q      <= '0;
         instrValid_q <= 1'b0;
         flags_q      <= '0;
         fields_q     <= '0;
      end else if (pcRequest) begin
         state_q      <= FETCH_WAIT;
         pc_q         <= pc_d;
         instrValid_q <= 1'b0;
         flags_q      <= '0;
      end else begin
         case (state_q)
            FETCH_WAIT: begin
               state_q <= FETCH_LOAD;
            end
            FETCH_LOAD: begin
               instr_q      <= bus_if.rom_q;
               flags_q      <= decodedFlags;
               fields_q     <= decodedFields;
               instrValid_q <= 1'b1;
               state_q      <= FETCH_HOLD;
            end
            FETCH_HOLD: begin
               state_q <= FETCH_HOLD;
            end
            default: begin
               state_q <= FETCH_WAIT;
            end
         endcase
      end
   end

   assign bus_if.rom_addr    = pc_q;
   assign bus_if.pc          = pc_q;
   assign bus_if.instr       = instr_q;
   assign bus_if.instr_valid = instrValid_q;
   assign bus_if.pause       = flags_q.pause;
   assign bus_if.br          = flags_q.br;
   assign bus_if.brz         = flags_q.brz;
   assign bus_if.addi        = flags_q.addi;
   assign bus_if.subi        = flags_q.subi;
   assign bus_if.sr0         = flags_q.sr0;
   assign bus_if.srh0        = flags_q.srh0;
   assign bus_if.clr         = flags_q.clr;
   assign bus_if.mov         = flags_q.mov;
   assign bus_if.mova        = flags_q.mova;
   assign bus_if.movr        = flags_q.movr;
   assign bus_if.movrhs      = flags_q.movrhs;
   assign bus_if.illegal     = flags_q.illegal;
   assign bus_if.rx          = fields_q.rx;
   assign bus_if.ry          = fields_q.ry;
   assign bus_if.imm4        = fields_q.imm4;

endmodule
